// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one downstream AXI read channel between M0 (ifetch) and M1 (load), one burst at a time.
// Optional READ_ARB_RR_EN selects round-robin arbitration; otherwise M1 has fixed priority.
module axi_read_arbiter #(
  parameter int IDW = 4,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic           ACLK,
  input  logic           ARESETn,
  input  logic [IDW-1:0] ARID_M0_i,
  input  logic [AW-1:0]  ARADDR_M0_i,
  input  logic [3:0]     ARLEN_M0_i,
  input  logic [2:0]     ARSIZE_M0_i,
  input  logic [1:0]     ARBURST_M0_i,
  input  logic           ARVALID_M0_i,
  output logic           ARREADY_M0_o,
  output logic [IDW-1:0] RID_M0_o,
  output logic [DW-1:0]  RDATA_M0_o,
  output logic [1:0]     RRESP_M0_o,
  output logic           RLAST_M0_o,
  output logic           RVALID_M0_o,
  input  logic           RREADY_M0_i,
  input  logic [IDW-1:0] ARID_M1_i,
  input  logic [AW-1:0]  ARADDR_M1_i,
  input  logic [3:0]     ARLEN_M1_i,
  input  logic [2:0]     ARSIZE_M1_i,
  input  logic [1:0]     ARBURST_M1_i,
  input  logic           ARVALID_M1_i,
  output logic           ARREADY_M1_o,
  output logic [IDW-1:0] RID_M1_o,
  output logic [DW-1:0]  RDATA_M1_o,
  output logic [1:0]     RRESP_M1_o,
  output logic           RLAST_M1_o,
  output logic           RVALID_M1_o,
  input  logic           RREADY_M1_i,
  output logic [IDW+3:0] ARID_S_o,
  output logic [AW-1:0]  ARADDR_S_o,
  output logic [3:0]     ARLEN_S_o,
  output logic [2:0]     ARSIZE_S_o,
  output logic [1:0]     ARBURST_S_o,
  output logic           ARVALID_S_o,
  input  logic           ARREADY_S_i,
  input  logic [IDW+3:0] RID_S_i,
  input  logic [DW-1:0]  RDATA_S_i,
  input  logic [1:0]     RRESP_S_i,
  input  logic           RLAST_S_i,
  input  logic           RVALID_S_i,
  output logic           RREADY_S_o
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state_q, state_d;
  logic g_q, g_d, arb, in_addr, in_data, r0, r1, done, unused_rid_tag;
  assign in_addr = state_q == ADDR;
  assign in_data = state_q == DATA;
  assign r0 = in_data & ~g_q;
  assign r1 = in_data & g_q;
  assign done = in_data & RVALID_S_i & RREADY_S_o & RLAST_S_i;
  // The tag bits of RID_S only matter to checkers; routing follows the registered grant.
  assign unused_rid_tag = ^RID_S_i[IDW+3:IDW];
`ifdef READ_ARB_RR_EN
  logic last_q;
  assign arb = (ARVALID_M0_i & ARVALID_M1_i) ? ~last_q : ARVALID_M1_i;
  always_ff @(posedge ACLK)
    if (!ARESETn) last_q <= 1'b1;
    else if (done) last_q <= g_q;
`else
  assign arb = ARVALID_M1_i;
`endif
  always_ff @(posedge ACLK)
    if (!ARESETn) begin
      state_q <= IDLE;
      g_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
    end
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    case (state_q)
      IDLE: if (ARVALID_M0_i | ARVALID_M1_i) begin
        state_d = ADDR;
        g_d     = arb;
      end
      ADDR: if (ARVALID_S_o & ARREADY_S_i) state_d = DATA;
      DATA: if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign ARVALID_S_o  = in_addr & (g_q ? ARVALID_M1_i : ARVALID_M0_i);
  assign ARID_S_o     = in_addr ? {3'b000, g_q, (g_q ? ARID_M1_i : ARID_M0_i)} : '0;
  assign ARADDR_S_o   = in_addr ? (g_q ? ARADDR_M1_i : ARADDR_M0_i) : '0;
  assign ARLEN_S_o    = in_addr ? (g_q ? ARLEN_M1_i : ARLEN_M0_i) : '0;
  assign ARSIZE_S_o   = in_addr ? (g_q ? ARSIZE_M1_i : ARSIZE_M0_i) : '0;
  assign ARBURST_S_o  = in_addr ? (g_q ? ARBURST_M1_i : ARBURST_M0_i) : '0;
  assign ARREADY_M0_o = in_addr & ~g_q & ARREADY_S_i;
  assign ARREADY_M1_o = in_addr & g_q & ARREADY_S_i;
  assign RREADY_S_o   = in_data & (g_q ? RREADY_M1_i : RREADY_M0_i);
  assign RVALID_M0_o  = r0 & RVALID_S_i;
  assign RID_M0_o     = r0 ? RID_S_i[IDW-1:0] : '0;
  assign RDATA_M0_o   = r0 ? RDATA_S_i : '0;
  assign RRESP_M0_o   = r0 ? RRESP_S_i : '0;
  assign RLAST_M0_o   = r0 & RLAST_S_i;
  assign RVALID_M1_o  = r1 & RVALID_S_i;
  assign RID_M1_o     = r1 ? RID_S_i[IDW-1:0] : '0;
  assign RDATA_M1_o   = r1 ? RDATA_S_i : '0;
  assign RRESP_M1_o   = r1 ? RRESP_S_i : '0;
  assign RLAST_M1_o   = r1 & RLAST_S_i;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed table vectors plus hand sequences for the read arbiter.
module tb_axi_read_arbiter;
  localparam int IDW = 4, AW = 32, DW = 32;
  logic ACLK = 0, ARESETn = 0;
  always #5 ACLK = ~ACLK;
  logic [IDW-1:0] arid0, arid1, rid0, rid1;
  logic [AW-1:0]  araddr0, araddr1, araddr_s;
  logic [3:0]     arlen0, arlen1, arlen_s;
  logic [2:0]     arsize0, arsize1, arsize_s;
  logic [1:0]     arburst0, arburst1, arburst_s, rresp0, rresp1, rresp_s;
  logic           v0, v1, ar0, ar1, rr0, rr1, rl0, rl1, rv0, rv1;
  logic [DW-1:0]  rdata0, rdata1, rdata_s;
  logic [IDW+3:0] arid_s, rid_s;
  logic           arvalid_s, ars, rlast_s, rvalid_s, rready_s;
  int errs = 0, checks = 0;
  logic m_last = 1'b1;

  axi_read_arbiter #(.IDW(IDW), .AW(AW), .DW(DW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID_M0_i(arid0), .ARADDR_M0_i(araddr0), .ARLEN_M0_i(arlen0), .ARSIZE_M0_i(arsize0),
    .ARBURST_M0_i(arburst0), .ARVALID_M0_i(v0), .ARREADY_M0_o(ar0), .RID_M0_o(rid0),
    .RDATA_M0_o(rdata0), .RRESP_M0_o(rresp0), .RLAST_M0_o(rl0), .RVALID_M0_o(rv0), .RREADY_M0_i(rr0),
    .ARID_M1_i(arid1), .ARADDR_M1_i(araddr1), .ARLEN_M1_i(arlen1), .ARSIZE_M1_i(arsize1),
    .ARBURST_M1_i(arburst1), .ARVALID_M1_i(v1), .ARREADY_M1_o(ar1), .RID_M1_o(rid1),
    .RDATA_M1_o(rdata1), .RRESP_M1_o(rresp1), .RLAST_M1_o(rl1), .RVALID_M1_o(rv1), .RREADY_M1_i(rr1),
    .ARID_S_o(arid_s), .ARADDR_S_o(araddr_s), .ARLEN_S_o(arlen_s), .ARSIZE_S_o(arsize_s),
    .ARBURST_S_o(arburst_s), .ARVALID_S_o(arvalid_s), .ARREADY_S_i(ars),
    .RID_S_i(rid_s), .RDATA_S_i(rdata_s), .RRESP_S_i(rresp_s), .RLAST_S_i(rlast_s),
    .RVALID_S_i(rvalid_s), .RREADY_S_o(rready_s)
  );

  typedef struct packed {
    logic [6:0] in;  // {v0, v1, ARREADY_S, RVALID_S, RLAST_S, RREADY_M0, RREADY_M1}
    logic [5:0] ex;  // {ARVALID_S, ARREADY_M0, ARREADY_M1, RVALID_M0, RVALID_M1, RREADY_S}
    logic [3:0] hi;  // ARID_S grant tag
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic add(input logic [6:0] i, input logic [5:0] e, input logic [3:0] h);
    tbl.push_back('{in: i, ex: e, hi: h});
  endtask

  task automatic clr();
    {v0, v1, ars, rvalid_s, rlast_s, rr0, rr1} = '0;
    rdata_s = '0; rid_s = '0; rresp_s = '0;
  endtask

  task automatic do_reset();
    @(negedge ACLK); ARESETn = 0; clr();
    @(negedge ACLK); ARESETn = 1; #1;
    m_last = 1'b1;
    chk("reset_out", {arvalid_s, ar0, ar1, rv0, rv1, rready_s, arid_s}, '0);
  endtask

  function automatic logic pick(input logic a, input logic b);
`ifdef READ_ARB_RR_EN
    return (a & b) ? ~m_last : b;
`else
    return b;
`endif
  endfunction

  // one single-beat burst with the given requesters; expects grant g
  task automatic do_burst(input logic g, input logic a, input logic b);
    @(negedge ACLK); clr(); v0 = a; v1 = b; #1;
    chk("arb_idle", {arvalid_s, ar0, ar1}, 3'b000);
    @(negedge ACLK); ars = 1; #1;
    chk("arb_tag", {arvalid_s, 3'(arid_s[7:4])}, {1'b1, 3'(g)});
    @(negedge ACLK); ars = 0; rvalid_s = 1; rlast_s = 1; rr0 = 1; rr1 = 1; rdata_s = 32'h55; #1;
    chk("arb_route", {rv0, rv1, rready_s}, {~g, g, 1'b1});
    m_last = g;
  endtask

  initial begin
    logic w;
    clr();
    arid0 = 4'hA; araddr0 = 32'h0000_0100; arlen0 = 4'd3; arsize0 = 3'd2; arburst0 = 2'd1;
    arid1 = 4'h5; araddr1 = 32'h0000_2000; arlen1 = 4'd2; arsize1 = 3'd3; arburst1 = 2'd2;
    @(negedge ACLK); @(negedge ACLK); ARESETn = 1; #1;
    chk("reset_state", {arvalid_s, ar0, ar1, rv0, rv1, rready_s, arid_s, araddr_s}, '0);
    add(7'b0000000, 6'b000000, 0);
    add(7'b1000000, 6'b000000, 0);
    add(7'b1010000, 6'b110000, 0);
    add(7'b0001010, 6'b000101, 0);
    add(7'b0001010, 6'b000101, 0);
    add(7'b0001010, 6'b000101, 0);
    add(7'b0001110, 6'b000101, 0);
    add(7'b0000000, 6'b000000, 0);
    add(7'b1000000, 6'b000000, 0);
    for (int i = 0; i < 5; i++) add(7'b1000000, 6'b100000, 0);
    add(7'b1010000, 6'b110000, 0);
    add(7'b0001101, 6'b000100, 0);
    add(7'b0001110, 6'b000101, 0);
    add(7'b0100000, 6'b000000, 0);
    add(7'b0010000, 6'b001000, 1);
    add(7'b0110000, 6'b101000, 1);
    add(7'b0001111, 6'b000011, 0);
    add(7'b0000000, 6'b000000, 0);
    foreach (tbl[i]) begin
      @(negedge ACLK);
      {v0, v1, ars, rvalid_s, rlast_s, rr0, rr1} = tbl[i].in;
      #1;
      chk($sformatf("row%0d_ctl", i), {arvalid_s, ar0, ar1, rv0, rv1, rready_s}, tbl[i].ex);
      chk($sformatf("row%0d_tag", i), arid_s[7:4], tbl[i].hi);
    end
    // M0 alone: fields muxed and four beats returned to M0 only
    @(negedge ACLK); clr(); v0 = 1; #1;
    @(negedge ACLK); ars = 1; #1;
    chk("t1_ar", {arid_s, araddr_s, arlen_s, arsize_s, arburst_s}, {8'h0A, 32'h100, 4'd3, 3'd2, 2'd1});
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK); clr(); rvalid_s = 1; rr0 = 1; rid_s = 8'h0A;
      rdata_s = 32'hD0 + k; rresp_s = 2'(k); rlast_s = (k == 3); #1;
      chk($sformatf("t1_beat%0d", k), {rv0, rv1, rid0, rdata0, rresp0, rl0, rdata1},
          {1'b1, 1'b0, 4'hA, 32'hD0 + k, 2'(k), k == 3, 32'h0});
    end
    @(negedge ACLK); clr(); rvalid_s = 1; #1;
    chk("t1_done", {rv0, rready_s, arvalid_s}, 3'b000);
    // M1 burst with backpressure on beat 2
    @(negedge ACLK); clr(); v1 = 1; #1;
    @(negedge ACLK); ars = 1; #1;
    chk("t5_ar", {arid_s, araddr_s, arlen_s}, {8'h15, 32'h2000, 4'd2});
    @(negedge ACLK); clr(); rvalid_s = 1; rr1 = 1; rid_s = 8'h15; rdata_s = 32'h11; #1;
    chk("t5_b1", {rv1, rdata1, rid1, rready_s}, {1'b1, 32'h11, 4'h5, 1'b1});
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK); rdata_s = 32'h22; rr1 = 0; rr0 = 1; #1;
      chk($sformatf("t5_stall%0d", k), {rv1, rdata1, rready_s, rv0}, {1'b1, 32'h22, 1'b0, 1'b0});
    end
    @(negedge ACLK); rr1 = 1; #1;
    chk("t5_b2", {rv1, rdata1, rready_s}, {1'b1, 32'h22, 1'b1});
    @(negedge ACLK); rdata_s = 32'h33; rlast_s = 1; #1;
    chk("t5_b3", {rv1, rdata1, rl1, rready_s}, {1'b1, 32'h33, 1'b1, 1'b1});
    @(negedge ACLK); clr(); #1;
    // reset in the middle of a burst
    @(negedge ACLK); v0 = 1; #1;
    @(negedge ACLK); ars = 1; #1;
    @(negedge ACLK); clr(); rvalid_s = 1; rr0 = 1; rdata_s = 32'h77; #1;
    chk("t6_data", {rv0, rdata0}, {1'b1, 32'h77});
    @(negedge ACLK); ARESETn = 0; #1;
    chk("t6_sync", {rv0, rdata0}, {1'b1, 32'h77});
    @(negedge ACLK); ARESETn = 1; #1;
    chk("t6_idle", {rv0, rv1, rready_s, arvalid_s, rdata0, arid_s}, '0);
    @(negedge ACLK); clr(); v0 = 1; #1;
    @(negedge ACLK); ars = 1; #1;
    chk("t6_new", {arvalid_s, ar0, arid_s, araddr_s}, {2'b11, 8'h0A, 32'h100});
    @(negedge ACLK); clr(); rvalid_s = 1; rlast_s = 1; rr0 = 1; #1;
    chk("t6_beat", {rv0, rl0, rready_s}, 3'b111);
    // simultaneous requests: winner then loser, then four back-to-back contended bursts
    do_reset();
    w = pick(1'b1, 1'b1);
    do_burst(w, 1'b1, 1'b1);
    do_burst(~w, w, ~w);
    for (int k = 0; k < 4; k++) do_burst(pick(1'b1, 1'b1), 1'b1, 1'b1);
    @(negedge ACLK); clr();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
